alu_mc: RTL

Parametrised multi-cycle successor to the processor's single-cycle 32-bit ALU. It keeps the existing 4-bit control encoding and flag outputs, and adds the following:
- generic WIDTH;
- arithmetic right shift;
- iterative shift-add multiply and restoring unsigned divide/remainder;
- a valid/ready handshake on input and output.

It sits in the execute stage of the multi-cycle datapath. It stalls the pipeline via in_ready while an iterative operation runs.

---
 rtl/alu_mc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic/arith/shift ops
// plus iterative shift-add multiply and restoring unsigned divide/remainder.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_A,
   input  logic [WIDTH-1:0] op_B,
   input  logic [3:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [3:0]           ctrl_q, ctrl_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [SHW:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic                 carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;

   logic                 sub_s, ovf_s, slt_s;
   logic [WIDTH-1:0]     bx_s;
   logic [WIDTH:0]       sum_s;
   logic [SHW-1:0]       sh_s;
   logic [WIDTH-1:0]     sc_res_s;
   logic                 sc_carry_s, sc_ovf_s;
   logic [WIDTH:0]       mul_add_s, div_shift_s, div_rem_s;
   logic                 div_ge_s;
   logic [2*WIDTH-1:0]   iter_acc_s;
   logic [WIDTH-1:0]     iter_res_s;

   // Single-cycle datapath, evaluated directly on the incoming operands
   always_comb begin
      sub_s      = (ctrl == 4'b0110) || (ctrl == 4'b0111) || (ctrl == 4'b0101);
      bx_s       = sub_s ? ~op_B : op_B;
      sum_s      = {1'b0, op_A} + {1'b0, bx_s} + {{WIDTH{1'b0}}, sub_s};
      ovf_s      = (op_A[WIDTH-1] == bx_s[WIDTH-1]) && (sum_s[WIDTH-1] != op_A[WIDTH-1]);
      slt_s      = (op_A[WIDTH-1] == op_B[WIDTH-1]) ? sum_s[WIDTH-1] : op_A[WIDTH-1];
      sh_s       = op_B[SHW-1:0];
      sc_res_s   = {WIDTH{1'b0}};
      sc_carry_s = 1'b0;
      sc_ovf_s   = 1'b0;
      case (ctrl)
         4'b0010, 4'b0110: begin
            sc_res_s   = sum_s[WIDTH-1:0];
            sc_carry_s = sum_s[WIDTH];
            sc_ovf_s   = ovf_s;
         end
         4'b0111: begin
            sc_res_s   = {{(WIDTH-1){1'b0}}, slt_s};
            sc_carry_s = sum_s[WIDTH];
            sc_ovf_s   = ovf_s;
         end
         4'b0101: begin
            sc_res_s   = {{(WIDTH-1){1'b0}}, ~sum_s[WIDTH]};
            sc_carry_s = sum_s[WIDTH];
            sc_ovf_s   = ovf_s;
         end
         4'b0000: sc_res_s = op_A & op_B;
         4'b0001: sc_res_s = op_A | op_B;
         4'b0011: sc_res_s = op_A ^ op_B;
         4'b1000: sc_res_s = op_A << sh_s;
         4'b1001: sc_res_s = op_A >> sh_s;
         4'b1010: sc_res_s = $unsigned($signed(op_A) >>> sh_s);
         default: sc_res_s = {WIDTH{1'b0}};
      endcase
   end

   // One iteration step: acc holds {hi, multiplier} for MUL, {remainder, quotient} for DIV
   always_comb begin
      mul_add_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge_s    = div_shift_s >= {1'b0, b_q};
      div_rem_s   = div_ge_s ? (div_shift_s - {1'b0, b_q}) : div_shift_s;
      if (ctrl_q[1]) begin
         iter_acc_s = {div_rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge_s};
      end else begin
         iter_acc_s = {mul_add_s, acc_q[WIDTH-1:1]};
      end
      iter_res_s = ctrl_q[0] ? iter_acc_s[2*WIDTH-1:WIDTH] : iter_acc_s[WIDTH-1:0];
   end

   // Next-state logic for the IDLE/BUSY/DONE controller and the result registers
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d    = op_A;
               b_d    = op_B;
               ctrl_d = ctrl;
               if (ctrl[3:2] == 2'b11) begin
                  state_d = BUSY;
                  cnt_d   = {(SHW+1){1'b0}};
                  acc_d   = {{WIDTH{1'b0}}, (ctrl[1] ? op_A : op_B)};
               end else begin
                  state_d = DONE;
                  res_d   = sc_res_s;
                  carry_d = sc_carry_s;
                  ovf_d   = sc_ovf_s;
                  zero_d  = (sc_res_s == {WIDTH{1'b0}});
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            acc_d = iter_acc_s;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               res_d   = iter_res_s;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               zero_d  = (iter_res_s == {WIDTH{1'b0}});
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         ctrl_q  <= 4'b0000;
         acc_q   <= {(2*WIDTH){1'b0}};
         cnt_q   <= {(SHW+1){1'b0}};
         res_q   <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign res       = res_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule
